// File: rtl/ics2115_pkg.sv
// ICS2115 bus master shared types.
// Chip port map, sequencer states and the queued command bundle.
package ics2115_pkg;

  localparam logic [1:0] ADDR_STAT = 2'd0;
  localparam logic [1:0] ADDR_SEL  = 2'd1;
  localparam logic [1:0] ADDR_DLO  = 2'd2;
  localparam logic [1:0] ADDR_DHI  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_GAP,
    ST_DLO,
    ST_DHI,
    ST_RSP
  } state_e;

  // reg is a keyword, so the register index is reg_idx
  typedef struct packed {
    logic        write;
    logic        wide;
    logic [7:0]  reg_idx;
    logic [15:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ics2115_cmd_fifo.sv
// Command FIFO for the ICS2115 bus master.
// Power-of-two depth; push is ignored when full, pop when empty.
module ics2115_cmd_fifo
  import ics2115_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  cmd_t wr_cmd,
  input  logic pop,
  output cmd_t rd_cmd,
  output logic empty,
  output logic full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] P_ONE = 1;
  localparam logic [AW:0]   C_ONE = 1;
  localparam logic [AW:0]   C_MAX = DEPTH;

  cmd_t          mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == C_MAX);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_cmd  = mem_q[rp_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + P_ONE;
      if (do_pop)  rp_q <= rp_q + P_ONE;
      if (do_push && !do_pop) cnt_q <= cnt_q + C_ONE;
      if (do_pop && !do_push) cnt_q <= cnt_q - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= wr_cmd;
  end

endmodule

// File: rtl/ics2115_bus_master.sv
// ICS2115 register bus master: queues commands and sequences
// select / data-low / data-high strobes with idle gaps between them.
module ics2115_bus_master
  import ics2115_pkg::*;
#(
  parameter int GAP       = 2,
  parameter int CMD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_wide,
  input  logic [7:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        busy,
  output logic [1:0]  ics_addr,
  output logic [7:0]  ics_din,
  input  logic [7:0]  ics_dout,
  output logic        ics_we,
  output logic        ics_re
);

  localparam bit         GAP_ON   = (GAP != 0);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);

  state_e      state_q, state_d;
  state_e      pend_q, pend_d;
  state_e      nxt;
  logic        adv;
  logic [3:0]  cnt_q, cnt_d;
  cmd_t        cur_q, cur_d;
  logic [7:0]  last_sel_q, last_sel_d;
  logic        sel_valid_q, sel_valid_d;
  logic [15:0] rsp_q, rsp_d;
  logic [1:0]  addr_q;

  cmd_t        head;
  cmd_t        in_cmd;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;

  assign in_cmd = '{
    write:   cmd_write,
    wide:    cmd_wide,
    reg_idx: cmd_reg,
    wdata:   cmd_wdata
  };

  assign cmd_ready = reset_n && !fifo_full;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_data  = rsp_q;

  ics2115_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_valid && cmd_ready),
    .wr_cmd  (in_cmd),
    .pop     (pop),
    .rd_cmd  (head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    last_sel_d  = last_sel_q;
    sel_valid_d = sel_valid_q;
    rsp_d       = rsp_q;
    pop         = 1'b0;
    nxt         = ST_IDLE;
    adv         = 1'b0;
    ics_we      = 1'b0;
    ics_re      = 1'b0;
    ics_din     = 8'h00;
    ics_addr    = addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop   = 1'b1;
          cur_d = head;
          if (sel_valid_q && head.reg_idx == last_sel_q)
            state_d = ST_DLO;
          else
            state_d = ST_SEL;
        end
      end
      ST_SEL: begin
        ics_we      = 1'b1;
        ics_addr    = ADDR_SEL;
        ics_din     = cur_q.reg_idx;
        last_sel_d  = cur_q.reg_idx;
        sel_valid_d = 1'b1;
        nxt         = ST_DLO;
        adv         = 1'b1;
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = pend_q;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_DLO: begin
        ics_addr = ADDR_DLO;
        ics_we   = cur_q.write;
        ics_re   = !cur_q.write;
        if (cur_q.write) ics_din = cur_q.wdata[7:0];
        else             rsp_d   = {8'h00, ics_dout};
        if (cur_q.wide) begin
          nxt = ST_DHI;
          adv = 1'b1;
        end else begin
          state_d = cur_q.write ? ST_IDLE : ST_RSP;
        end
      end
      ST_DHI: begin
        ics_addr = ADDR_DHI;
        ics_we   = cur_q.write;
        ics_re   = !cur_q.write;
        if (cur_q.write) ics_din = cur_q.wdata[15:8];
        else             rsp_d   = {ics_dout, rsp_q[7:0]};
        state_d = cur_q.write ? ST_IDLE : ST_RSP;
      end
      ST_RSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // a strobe that has a following phase waits out the gap first
    if (adv) begin
      if (GAP_ON) begin
        state_d = ST_GAP;
        pend_d  = nxt;
        cnt_d   = 4'd0;
      end else begin
        state_d = nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= ST_IDLE;
      cnt_q       <= 4'd0;
      cur_q       <= '0;
      last_sel_q  <= 8'h00;
      sel_valid_q <= 1'b0;
      rsp_q       <= 16'h0000;
      addr_q      <= 2'd0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      last_sel_q  <= last_sel_d;
      sel_valid_q <= sel_valid_d;
      rsp_q       <= rsp_d;
      addr_q      <= ics_addr;
    end
  end

endmodule
